// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the sequential adder reduction block.
package adder_seq_pkg;

  localparam int DEF_ADDER_WIDTH  = 64;
  localparam int DEF_NUM_OPERANDS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Result width: enough headroom that summing num_operands full-scale values cannot overflow.
  function automatic int sum_width(input int adder_width, input int num_operands);
    return adder_width + $clog2(num_operands);
  endfunction

endpackage

// File: rtl/adder_seq_acc.sv
// Accumulator register with a zero-extending two-input adder; load overrides add.
module adder_seq_acc #(
  parameter int ADDER_WIDTH = 64,
  parameter int SUM_WIDTH   = 67
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   add,
  input  logic [ADDER_WIDTH-1:0] operand,
  output logic [SUM_WIDTH-1:0]   acc
);

  logic [SUM_WIDTH-1:0] acc_q;
  logic [SUM_WIDTH-1:0] acc_d;
  logic [SUM_WIDTH-1:0] operand_ext;

  assign operand_ext = SUM_WIDTH'(operand);

  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = operand_ext;
    end else if (add) begin
      acc_d = acc_q + operand_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/adder_reduce_seq.sv
// Folds NUM_OPERANDS operands into one sum through a single adder, valid/ready on both sides.
// Optional synchronous frame abort port 'clear' is built when ADDER_SEQ_CLEAR_EN is defined.
module adder_reduce_seq
  import adder_seq_pkg::*;
#(
  parameter  int ADDER_WIDTH  = DEF_ADDER_WIDTH,
  parameter  int NUM_OPERANDS = DEF_NUM_OPERANDS,
  localparam int SUM_WIDTH    = sum_width(ADDER_WIDTH, NUM_OPERANDS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDER_WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SUM_WIDTH-1:0]   out_sum,
`ifdef ADDER_SEQ_CLEAR_EN
  input  logic                   clear,
`endif
  output logic                   busy
);

  localparam int CNT_W = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPERANDS - 1);

  if (NUM_OPERANDS < 2 || NUM_OPERANDS > 16 ||
      (NUM_OPERANDS & (NUM_OPERANDS - 1)) != 0) begin : g_bad_num_operands
    $error("adder_reduce_seq: NUM_OPERANDS must be a power of two in 2..16");
  end

  state_t               state_q;
  state_t               state_d;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic                 accept;
  logic                 clear_w;
  logic                 acc_load;
  logic                 acc_add;
  logic [ADDER_WIDTH-1:0] acc_operand;

`ifdef ADDER_SEQ_CLEAR_EN
  assign clear_w = clear;
`else
  assign clear_w = 1'b0;
`endif

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ACCUM);
  assign accept    = in_valid && in_ready;

  // Abort is a load of zero so it always wins over a coincident accept.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_load    = 1'b0;
    acc_add     = 1'b0;
    acc_operand = in_data;
    if (clear_w) begin
      state_d     = IDLE;
      count_d     = '0;
      acc_load    = 1'b1;
      acc_operand = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_load = 1'b1;
            count_d  = CNT_W'(1);
            state_d  = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_add = 1'b1;
            if (count_q == LAST_CNT) begin
              count_d = '0;
              state_d = DONE;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  adder_seq_acc #(
    .ADDER_WIDTH (ADDER_WIDTH),
    .SUM_WIDTH   (SUM_WIDTH)
  ) u_acc (
    .clk     (clk),
    .rst     (reset),
    .load    (acc_load),
    .add     (acc_add),
    .operand (acc_operand),
    .acc     (out_sum)
  );

endmodule

// File: tb/tb_adder_reduce_seq.sv
// Directed bench for adder_reduce_seq (64-bit operands, 8 per frame); clear test needs ADDER_SEQ_CLEAR_EN.
module tb_adder_reduce_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [66:0] out_sum;
  logic        busy;
`ifdef ADDER_SEQ_CLEAR_EN
  logic        clear;
`endif

  int checks = 0;
  int errors = 0;

  adder_reduce_seq #(
    .ADDER_WIDTH  (64),
    .NUM_OPERANDS (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
`ifdef ADDER_SEQ_CLEAR_EN
    .clear     (clear),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Holds in_valid high with v until one accept edge has passed; returns 1ns after that edge.
  task automatic push(input logic [63:0] v);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
    end
    check("push_accept", accepted, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef ADDER_SEQ_CLEAR_EN
    clear     = 1'b0;
`endif
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_sum", out_sum, 0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    tick();

    // Back-to-back 1..8, consumer always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push(64'(i));
      if (i < 8) begin
        check("b2b_busy", busy, 1);
        check("b2b_no_valid", out_valid, 0);
      end
    end
    in_valid = 1'b0;
    check("b2b_valid", out_valid, 1);
    check("b2b_sum", out_sum, 36);
    check("b2b_in_ready_low", in_ready, 0);
    check("b2b_busy_done", busy, 0);
    $display("frame b2b sum=%0d", out_sum);
    tick();
    check("b2b_valid_one_cycle", out_valid, 0);
    check("b2b_in_ready_back", in_ready, 1);

    // Full-scale operands: carries must reach the top bits
    for (int i = 0; i < 8; i++) push(64'hFFFF_FFFF_FFFF_FFFF);
    in_valid = 1'b0;
    check("max_sum", out_sum, 67'h7_FFFF_FFFF_FFFF_FFF8);
    $display("frame max sum=%0h", out_sum);
    tick();

    // Backpressure: result held while a producer keeps offering 9
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(64'd3);
    in_data = 64'd9;
    for (int c = 0; c < 5; c++) begin
      check("hold_sum", out_sum, 24);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      tick();
    end
    $display("frame hold sum=%0d", out_sum);
    out_ready = 1'b1;
    tick();
    check("hold_release", out_valid, 0);
    for (int i = 0; i < 8; i++) push(64'd9);
    in_valid = 1'b0;
    check("nines_sum", out_sum, 72);
    check("nines_valid", out_valid, 1);
    $display("frame nines sum=%0d", out_sum);
    tick();

    // Random bubbles on in_valid
    check("bub_idle_busy", busy, 0);
    for (int i = 1; i <= 8; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        tick();
        check("bub_gap_busy", busy, (i > 1) ? 1 : 0);
      end
      push(64'(10 * i));
      if (i < 8) check("bub_busy", busy, 1);
    end
    in_valid = 1'b0;
    check("bub_sum", out_sum, 360);
    check("bub_busy_done", busy, 0);
    $display("frame bubbles sum=%0d", out_sum);
    tick();

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 3; i++) push(64'd1);
    in_valid = 1'b0;
    check("pre_rst_busy", busy, 1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_sum", out_sum, 0);
    #1;
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) push(64'd1);
    in_valid = 1'b0;
    check("post_rst_sum", out_sum, 8);
    $display("frame after reset sum=%0d", out_sum);
    tick();

`ifdef ADDER_SEQ_CLEAR_EN
    // Clear coincident with a 5th operand: operand dropped, frame restarted
    for (int i = 0; i < 4; i++) push(64'd5);
    in_valid = 1'b1;
    in_data  = 64'd5;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_sum", out_sum, 0);
    check("clr_valid", out_valid, 0);
    for (int i = 0; i < 8; i++) push(64'd2);
    in_valid = 1'b0;
    check("post_clr_sum", out_sum, 16);
    $display("frame after clear sum=%0d", out_sum);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
